// File: rtl/mips32_isa_pkg.sv
// Shared MIPS32 ISA definitions: opcodes, opcode classes, loader states and
// error codes. Used by the program loader and by the pipelined core.
package mips32_isa_pkg;

  // Opcodes
  localparam logic [5:0] OP_ADD   = 6'h00;
  localparam logic [5:0] OP_SUB   = 6'h01;
  localparam logic [5:0] OP_AND   = 6'h02;
  localparam logic [5:0] OP_OR    = 6'h03;
  localparam logic [5:0] OP_SLT   = 6'h04;
  localparam logic [5:0] OP_MUL   = 6'h05;
  localparam logic [5:0] OP_LW    = 6'h08;
  localparam logic [5:0] OP_SW    = 6'h09;
  localparam logic [5:0] OP_ADDI  = 6'h0A;
  localparam logic [5:0] OP_SUBI  = 6'h0B;
  localparam logic [5:0] OP_SLTI  = 6'h0C;
  localparam logic [5:0] OP_BNEQZ = 6'h0D;
  localparam logic [5:0] OP_BEQZ  = 6'h0E;
  localparam logic [5:0] OP_HLT   = 6'h3F;

  // Instruction classes, which select the word layout
  typedef enum logic [2:0] {
    CLS_R   = 3'd0,
    CLS_I   = 3'd1,
    CLS_BR  = 3'd2,
    CLS_HLT = 3'd3,
    CLS_BAD = 3'd4
  } op_class_t;

  // Loader session states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } loader_state_t;

  // Abort reasons reported on err_code
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OPCODE   = 2'b01;
  localparam logic [1:0] ERR_OVERFLOW = 2'b10;

  // Map an opcode to its encoding class; unknown opcodes are CLS_BAD
  function automatic op_class_t op_class(input logic [5:0] op);
    op_class_t cls;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: cls = CLS_R;
      OP_LW, OP_SW, OP_ADDI, OP_SUBI, OP_SLTI:       cls = CLS_I;
      OP_BNEQZ, OP_BEQZ:                             cls = CLS_BR;
      OP_HLT:                                        cls = CLS_HLT;
      default:                                       cls = CLS_BAD;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Instruction-field stream into the program loader.
// Handshake: the master holds valid and all fields stable while valid is
// high; a transfer happens on every rising clk edge where valid && ready,
// one instruction per cycle sustained. ready never depends on valid.
interface mips32_prog_loader_if #(
  parameter int ADDR_W = 10
) ();
  logic              valid;
  logic              ready;
  logic [5:0]        op;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [ADDR_W-1:0] target;

  modport master (output valid, op, rs, rt, rd, imm, target, input ready);
  modport slave  (input valid, op, rs, rt, rd, imm, target, output ready);
endinterface

// File: rtl/mips32_instr_encoder.sv
// Combinational instruction encoder: builds the 32-bit word for the current
// fields at write pointer ptr_i and flags opcodes outside the ISA.
// Branch offsets are relative to ptr_i+1; ADDR_W must be at most 15 so the
// signed offset fits the 16-bit field.
module mips32_instr_encoder
  import mips32_isa_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic [5:0]        op_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [15:0]       imm_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic [ADDR_W-1:0] ptr_i,
  output logic [31:0]       word_o,
  output logic              invalid_o
);

  localparam logic [ADDR_W:0] ONE_W = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] off_raw;
  logic [15:0]     off_ext;

  // Signed branch offset, one bit wider than the address so ptr+1 never wraps
  always_comb begin
    off_raw = {1'b0, target_i} - ({1'b0, ptr_i} + ONE_W);
    off_ext = 16'($signed(off_raw));
  end

  // Select the word layout by opcode class
  always_comb begin
    word_o    = '0;
    invalid_o = 1'b0;
    case (op_class(op_i))
      CLS_R:   word_o = {op_i, rs_i, rt_i, rd_i, 11'b0};
      CLS_I:   word_o = {op_i, rs_i, rt_i, imm_i};
      CLS_BR:  word_o = {op_i, rs_i, 5'b0, off_ext};
      CLS_HLT: word_o = {OP_HLT, 26'b0};
      default: invalid_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/mips32_prog_loader.sv
// Program loader: accepts instruction fields, encodes them and writes them
// to consecutive word addresses from base_addr_i until HLT, an invalid
// opcode or the top of memory ends the session.
module mips32_prog_loader
  import mips32_isa_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [ADDR_W-1:0]   base_addr_i,
  mips32_prog_loader_if.slave in_if,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [31:0]         mem_wdata_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [1:0]          err_code_o,
  output logic [ADDR_W:0]     word_count_o,
  output loader_state_t       state_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W-1:0] PTR_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};

  loader_state_t     state_q;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              done_q;
  logic              err_q;
  logic [1:0]        err_code_q;

  logic [31:0]       enc_word;
  logic              enc_invalid;
  logic              is_hlt;
  logic              at_last;

  mips32_instr_encoder #(.ADDR_W(ADDR_W)) u_enc (
    .op_i      (in_if.op),
    .rs_i      (in_if.rs),
    .rt_i      (in_if.rt),
    .rd_i      (in_if.rd),
    .imm_i     (in_if.imm),
    .target_i  (in_if.target),
    .ptr_i     (ptr_q),
    .word_o    (enc_word),
    .invalid_o (enc_invalid)
  );

  // Next pointer/count values and transfer qualifiers
  always_comb begin
    ptr_d   = ptr_q + PTR_ONE;
    count_d = count_q + CNT_ONE;
    is_hlt  = (in_if.op == OP_HLT);
    at_last = (ptr_q == LAST_ADDR);
  end

  // Session FSM with registered memory-write and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      count_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state_q    <= ST_LOAD;
            ptr_q      <= base_addr_i;
            count_q    <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
          end
        end
        ST_LOAD: begin
          // ready is high throughout LOAD, so valid alone marks a transfer
          if (in_if.valid) begin
            if (enc_invalid) begin
              state_q    <= ST_ERR;
              err_q      <= 1'b1;
              err_code_q <= ERR_OPCODE;
            end else begin
              mem_we_q    <= 1'b1;
              mem_addr_q  <= ptr_q;
              mem_wdata_q <= enc_word;
              count_q     <= count_d;
              // The pointer saturates at the top of memory instead of wrapping
              if (!at_last) begin
                ptr_q <= ptr_d;
              end
              if (is_hlt) begin
                state_q <= ST_DONE;
                done_q  <= 1'b1;
              end else if (at_last) begin
                state_q    <= ST_ERR;
                err_q      <= 1'b1;
                err_code_q <= ERR_OVERFLOW;
              end
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_if.ready  = (state_q == ST_LOAD);
  assign busy_o       = (state_q == ST_LOAD);
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign done_o       = done_q;
  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign word_count_o = count_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_mips32_prog_loader.sv
// Directed bench for mips32_prog_loader with hand-computed instruction words.
module tb_mips32_prog_loader;
  import mips32_isa_pkg::*;

  localparam int ADDR_W = 10;

  typedef struct {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [15:0] imm;
    logic [9:0]  tgt;
    logic [31:0] word;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   word_count;
  loader_state_t     state;

  logic [41:0] exp_q[$];
  int          n_cmp;
  int          n_mis;
  vec_t        s1[11];

  mips32_prog_loader_if #(.ADDR_W(ADDR_W)) bus ();

  mips32_prog_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .in_if        (bus.slave),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .busy_o       (busy),
    .done_o       (done),
    .err_o        (err),
    .err_code_o   (err_code),
    .word_count_o (word_count),
    .state_o      (state)
  );

  // Clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic expect_wr(input logic [9:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Called at a falling edge; returns at the next falling edge
  task automatic do_start(input logic [9:0] base);
    start     = 1'b1;
    base_addr = base;
    @(negedge clk);
    start     = 1'b0;
  endtask

  // Present one field set for one rising edge; valid stays high on return
  task automatic send(input logic [5:0] op, input logic [4:0] rs, input logic [4:0] rt,
                      input logic [4:0] rd, input logic [15:0] imm, input logic [9:0] tgt);
    bus.valid  = 1'b1;
    bus.op     = op;
    bus.rs     = rs;
    bus.rt     = rt;
    bus.rd     = rd;
    bus.imm    = imm;
    bus.target = tgt;
    @(negedge clk);
  endtask

  task automatic idle();
    bus.valid = 1'b0;
  endtask

  // Scoreboard: every write strobe must match the oldest expected write
  always @(negedge clk) begin
    logic [41:0] e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'(mem_addr), 32'h7FFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 32'(mem_addr), 32'(e[41:32]));
        check("wr_data", mem_wdata, e[31:0]);
      end
    end
  end

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    bus.valid = 1'b0;
    bus.op = '0;
    bus.rs = '0;
    bus.rt = '0;
    bus.rd = '0;
    bus.imm = '0;
    bus.target = '0;

    s1[0]  = '{6'h0A, 5'd0,  5'd10, 5'd0,  16'h00C8, 10'd0, 32'h280A00C8};
    s1[1]  = '{6'h0A, 5'd0,  5'd2,  5'd0,  16'h0001, 10'd0, 32'h28020001};
    s1[2]  = '{6'h05, 5'd2,  5'd3,  5'd2,  16'hFFFF, 10'd0, 32'h14431000};
    s1[3]  = '{6'h01, 5'd5,  5'd6,  5'd4,  16'h1234, 10'd0, 32'h04A62000};
    s1[4]  = '{6'h09, 5'd1,  5'd7,  5'd31, 16'h0010, 10'd0, 32'h24270010};
    s1[5]  = '{6'h08, 5'd31, 5'd1,  5'd0,  16'hFFFF, 10'd0, 32'h23E1FFFF};
    s1[6]  = '{6'h0C, 5'd2,  5'd3,  5'd0,  16'h8000, 10'd0, 32'h30438000};
    s1[7]  = '{6'h03, 5'd1,  5'd2,  5'd3,  16'h0000, 10'd0, 32'h0C221800};
    s1[8]  = '{6'h0D, 5'd3,  5'd7,  5'd0,  16'h0000, 10'd5, 32'h3460FFFC};
    s1[9]  = '{6'h0E, 5'd4,  5'd0,  5'd0,  16'h0000, 10'd9, 32'h3880FFFF};
    s1[10] = '{6'h3F, 5'd1,  5'd2,  5'd3,  16'hFFFF, 10'd0, 32'hFC000000};

    // Reset values
    @(negedge clk);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_word_count", 32'(word_count), 32'd0);
    check("rst_ready", 32'(bus.ready), 32'd0);
    check("rst_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_state", 32'(state), 32'(ST_IDLE));

    // Session at base 0: eleven instructions ending with HLT at address 10
    do_start(10'd0);
    check("s1_busy", 32'(busy), 32'd1);
    check("s1_ready", 32'(bus.ready), 32'd1);
    check("s1_count0", 32'(word_count), 32'd0);
    for (int i = 0; i < 11; i++) expect_wr(10'(i), s1[i].word);
    for (int i = 0; i < 11; i++) begin
      send(s1[i].op, s1[i].rs, s1[i].rt, s1[i].rd, s1[i].imm, s1[i].tgt);
      if (i == 0) check("s1_first_we", 32'(mem_we), 32'd1);
      if (i == 2) check("s1_count3", 32'(word_count), 32'd3);
    end
    idle();
    check("hlt_done", 32'(done), 32'd1);
    check("hlt_ready", 32'(bus.ready), 32'd0);
    check("hlt_busy", 32'(busy), 32'd0);
    check("hlt_count", 32'(word_count), 32'd11);
    check("hlt_state", 32'(state), 32'(ST_DONE));
    // valid pulses after HLT must not write
    send(OP_ADD, 5'd1, 5'd1, 5'd1, 16'h0, 10'd0);
    idle();
    @(negedge clk);
    send(OP_ADD, 5'd2, 5'd2, 5'd2, 16'h0, 10'd0);
    idle();
    @(negedge clk);
    check("hlt_hold_done", 32'(done), 32'd1);
    check("hlt_hold_count", 32'(word_count), 32'd11);

    // New session at base 8: forward branch, then an invalid opcode
    do_start(10'd8);
    check("s2_done_clr", 32'(done), 32'd0);
    check("s2_busy", 32'(busy), 32'd1);
    check("s2_count0", 32'(word_count), 32'd0);
    expect_wr(10'd8, 32'h3460000B);
    send(OP_BNEQZ, 5'd3, 5'd0, 5'd0, 16'h0, 10'd20);
    send(6'h07, 5'd1, 5'd2, 5'd3, 16'h0, 10'd0);
    idle();
    check("bad_err", 32'(err), 32'd1);
    check("bad_code", 32'(err_code), 32'd1);
    check("bad_state", 32'(state), 32'(ST_ERR));
    check("bad_ready", 32'(bus.ready), 32'd0);
    check("bad_count", 32'(word_count), 32'd1);
    @(negedge clk);
    check("bad_hold_code", 32'(err_code), 32'd1);

    // Recover from ERR into a session that runs off the top of memory
    do_start(10'd1022);
    check("ov_err_clr", 32'(err), 32'd0);
    check("ov_code_clr", 32'(err_code), 32'd0);
    check("ov_busy", 32'(busy), 32'd1);
    expect_wr(10'd1022, 32'h00430800);
    expect_wr(10'd1023, 32'h00430800);
    for (int i = 0; i < 3; i++) send(OP_ADD, 5'd2, 5'd3, 5'd1, 16'h0, 10'd0);
    idle();
    check("ov_err", 32'(err), 32'd1);
    check("ov_code", 32'(err_code), 32'd2);
    check("ov_count", 32'(word_count), 32'd2);
    check("ov_ready", 32'(bus.ready), 32'd0);
    check("ov_done", 32'(done), 32'd0);
    @(negedge clk);
    check("ov_state", 32'(state), 32'(ST_ERR));

    // Reset right after a transfer suppresses its write
    do_start(10'd0);
    bus.valid  = 1'b1;
    bus.op     = OP_ADD;
    bus.rs     = 5'd1;
    bus.rt     = 5'd2;
    bus.rd     = 5'd3;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.valid = 1'b0;
    #1;
    check("ar_mem_we", 32'(mem_we), 32'd0);
    check("ar_mem_addr", 32'(mem_addr), 32'd0);
    check("ar_mem_wdata", mem_wdata, 32'd0);
    check("ar_busy", 32'(busy), 32'd0);
    check("ar_count", 32'(word_count), 32'd0);
    check("ar_err_code", 32'(err_code), 32'd0);
    check("ar_ready", 32'(bus.ready), 32'd0);
    check("ar_state", 32'(state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar_post_state", 32'(state), 32'(ST_IDLE));
    check("ar_post_we", 32'(mem_we), 32'd0);

    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
